// File: rtl/ctrl_decoder_seq.sv
// Registered instruction decoder for the 9-bit accumulator core: accept handshake,
// multi-put immediate building and a wait-state FSM that stalls fetch during loads.
module ctrl_decoder_seq #(
  parameter int INSTR_W  = 9,
  parameter int OPC_W    = 5,
  parameter int CTR_W    = 12,
  parameter int IMM_W    = 16,
  parameter int MEM_WAIT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instruction,
  input  logic [CTR_W-1:0]   instr_ROM_ctr,
  output logic               stall,
  output logic               out_valid,
  output logic               branchFlag,
  output logic               memToRegFlag,
  output logic               memWriteFlag,
  output logic               regWriteFlag,
  output logic               putEn,
  output logic               opEn,
  output logic               immtoRegFlag,
  output logic               illegal,
  output logic [3:0]         ALUOp,
  output logic [IMM_W-1:0]   value,
  output logic [CTR_W-1:0]   control_ctr
);

  localparam int PUT_MAX = IMM_W / 8;
  localparam int PCNT_W  = $clog2(PUT_MAX + 1);
  localparam int WCNT_W  = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

  typedef enum logic {S_IDLE, S_MEM_WAIT} state_t;

  typedef struct packed {
    logic       branch;
    logic       mem_to_reg;
    logic       mem_write;
    logic       reg_write;
    logic       imm_to_reg;
    logic       illegal;
    logic [3:0] alu_op;
  } dec_t;

  localparam dec_t DEC_IDLE = '{branch: 1'b0, mem_to_reg: 1'b0, mem_write: 1'b0,
                                reg_write: 1'b0, imm_to_reg: 1'b0, illegal: 1'b0,
                                alu_op: 4'hF};

  function automatic dec_t decode_op(input logic [OPC_W-1:0] opc);
    dec_t d;
    d = DEC_IDLE;
    d.reg_write = 1'b1;
    case (int'(opc))
      0:  d.imm_to_reg = 1'b1;
      1:  d.mem_to_reg = 1'b1;
      2:  begin d.mem_write = 1'b1; d.reg_write = 1'b0; end
      3:  d.alu_op = 4'b0101;
      4:  d.alu_op = 4'b0110;
      5:  d.alu_op = 4'b0001;
      6:  d.alu_op = 4'b0010;
      7:  d.alu_op = 4'b0000;
      8:  begin d.branch = 1'b1; d.reg_write = 1'b0; end
      9:  begin d.alu_op = 4'b1001; d.reg_write = 1'b0; end
      10: begin d.alu_op = 4'b0111; d.reg_write = 1'b0; end
      11: begin d.alu_op = 4'b1000; d.reg_write = 1'b0; end
      12: d.alu_op = 4'b0011;
      13: d.alu_op = 4'b0100;
      14: d.alu_op = 4'b1010;
      15: d.alu_op = 4'b1011;
      16: d.alu_op = 4'b1100;
      default: begin d.reg_write = 1'b0; d.illegal = 1'b1; end
    endcase
    return d;
  endfunction

  state_t              state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [IMM_W-1:0]    acc_q, acc_d;
  logic [PCNT_W-1:0]   put_cnt_q, put_cnt_d;
  logic [CTR_W-1:0]    last_ctr_q, last_ctr_d;
  logic                last_vld_q, last_vld_d;
  logic [IMM_W-1:0]    pend_value_q, pend_value_d;
  logic [CTR_W-1:0]    pend_ctr_q, pend_ctr_d;
  logic                out_valid_q, out_valid_d;
  dec_t                dec_q, dec_d;
  logic                put_en_q, put_en_d;
  logic                op_en_q, op_en_d;
  logic [IMM_W-1:0]    value_q, value_d;
  logic [CTR_W-1:0]    ctr_q, ctr_d;

  logic                itype;
  logic [7:0]          put_byte;
  logic [OPC_W-1:0]    opc;
  logic                accept;
  dec_t                dec_in;
  logic [IMM_W-1:0]    acc_shift;
  logic [IMM_W-1:0]    run_value;

  assign itype    = instruction[0];
  assign put_byte = instruction[8:1];
  assign opc      = instruction[OPC_W:1];
  assign dec_in   = decode_op(opc);

  // A single-byte accumulator simply takes the new byte.
  if (IMM_W == 8) begin : g_acc8
    assign acc_shift = put_byte;
  end else begin : g_accn
    assign acc_shift = {acc_q[IMM_W-9:0], put_byte};
  end

  assign run_value = (put_cnt_q != '0) ? acc_q : IMM_W'(put_byte);
  assign accept    = instr_valid && (state_q == S_IDLE) &&
                     (!last_vld_q || (instr_ROM_ctr != last_ctr_q));

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    acc_d        = acc_q;
    put_cnt_d    = put_cnt_q;
    last_ctr_d   = last_ctr_q;
    last_vld_d   = last_vld_q;
    pend_value_d = pend_value_q;
    pend_ctr_d   = pend_ctr_q;
    out_valid_d  = 1'b0;
    dec_d        = DEC_IDLE;
    put_en_d     = 1'b0;
    op_en_d      = 1'b0;
    value_d      = value_q;
    ctr_d        = ctr_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          last_ctr_d = instr_ROM_ctr;
          last_vld_d = 1'b1;
          if (itype) begin
            acc_d = acc_shift;
            if (put_cnt_q != PCNT_W'(PUT_MAX)) put_cnt_d = put_cnt_q + PCNT_W'(1);
            out_valid_d = 1'b1;
            put_en_d    = 1'b1;
            value_d     = acc_shift;
            ctr_d       = instr_ROM_ctr;
          end else begin
            acc_d     = '0;
            put_cnt_d = '0;
            // Loads park their result until the memory wait has elapsed.
            if ((MEM_WAIT > 0) && dec_in.mem_to_reg) begin
              state_d      = S_MEM_WAIT;
              wcnt_d       = WCNT_W'(MEM_WAIT);
              pend_value_d = run_value;
              pend_ctr_d   = instr_ROM_ctr;
            end else begin
              out_valid_d = 1'b1;
              op_en_d     = 1'b1;
              dec_d       = dec_in;
              value_d     = run_value;
              ctr_d       = instr_ROM_ctr;
            end
          end
        end
      end
      S_MEM_WAIT: begin
        if (wcnt_q == WCNT_W'(1)) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b1;
          op_en_d     = 1'b1;
          dec_d       = decode_op(OPC_W'(1));
          value_d     = pend_value_q;
          ctr_d       = pend_ctr_q;
        end else begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_q       <= '0;
      acc_q        <= '0;
      put_cnt_q    <= '0;
      last_ctr_q   <= '0;
      last_vld_q   <= 1'b0;
      pend_value_q <= '0;
      pend_ctr_q   <= '0;
      out_valid_q  <= 1'b0;
      dec_q        <= DEC_IDLE;
      put_en_q     <= 1'b0;
      op_en_q      <= 1'b0;
      value_q      <= '0;
      ctr_q        <= '1;
    end else begin
      wcnt_q       <= wcnt_d;
      acc_q        <= acc_d;
      put_cnt_q    <= put_cnt_d;
      last_ctr_q   <= last_ctr_d;
      last_vld_q   <= last_vld_d;
      pend_value_q <= pend_value_d;
      pend_ctr_q   <= pend_ctr_d;
      out_valid_q  <= out_valid_d;
      dec_q        <= dec_d;
      put_en_q     <= put_en_d;
      op_en_q      <= op_en_d;
      value_q      <= value_d;
      ctr_q        <= ctr_d;
    end
  end

  assign stall        = (state_q == S_MEM_WAIT);
  assign out_valid    = out_valid_q;
  assign branchFlag   = dec_q.branch;
  assign memToRegFlag = dec_q.mem_to_reg;
  assign memWriteFlag = dec_q.mem_write;
  assign regWriteFlag = dec_q.reg_write;
  assign immtoRegFlag = dec_q.imm_to_reg;
  assign illegal      = dec_q.illegal;
  assign ALUOp        = dec_q.alu_op;
  assign putEn        = put_en_q;
  assign opEn         = op_en_q;
  assign value        = value_q;
  assign control_ctr  = ctr_q;

endmodule

// File: tb/tb_ctrl_decoder_seq.sv
// Bench for ctrl_decoder_seq: directed scenarios plus random traffic, all checked every
// cycle against a byte-queue / lookup-table model of the decoder.
module tb_ctrl_decoder_seq;
  localparam int INSTR_W  = 9;
  localparam int OPC_W    = 5;
  localparam int CTR_W    = 12;
  localparam int IMM_W    = 16;
  localparam int MEM_WAIT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               instr_valid;
  logic [INSTR_W-1:0] instruction;
  logic [CTR_W-1:0]   instr_ROM_ctr;
  logic               stall, out_valid, branchFlag, memToRegFlag, memWriteFlag;
  logic               regWriteFlag, putEn, opEn, immtoRegFlag, illegal;
  logic [3:0]         ALUOp;
  logic [IMM_W-1:0]   value;
  logic [CTR_W-1:0]   control_ctr;

  ctrl_decoder_seq #(
    .INSTR_W(INSTR_W), .OPC_W(OPC_W), .CTR_W(CTR_W), .IMM_W(IMM_W), .MEM_WAIT(MEM_WAIT)
  ) dut (
    .clk(clk), .reset(rst), .instr_valid(instr_valid), .instruction(instruction),
    .instr_ROM_ctr(instr_ROM_ctr), .stall(stall), .out_valid(out_valid),
    .branchFlag(branchFlag), .memToRegFlag(memToRegFlag), .memWriteFlag(memWriteFlag),
    .regWriteFlag(regWriteFlag), .putEn(putEn), .opEn(opEn), .immtoRegFlag(immtoRegFlag),
    .illegal(illegal), .ALUOp(ALUOp), .value(value), .control_ctr(control_ctr)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Model state and expected outputs for the current cycle
  logic [7:0]       mq[$];
  logic [CTR_W-1:0] m_last_ctr;
  bit               m_last_vld;
  int               m_wait;
  logic [IMM_W-1:0] m_pend_value;
  logic [CTR_W-1:0] m_pend_ctr;
  logic exp_stall, exp_valid, exp_branch, exp_m2r, exp_mw, exp_rw, exp_put, exp_op, exp_imm, exp_ill;
  logic [3:0]       exp_alu;
  logic [IMM_W-1:0] exp_value;
  logic [CTR_W-1:0] exp_ctr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [IMM_W-1:0] q_value();
    logic [IMM_W-1:0] v;
    v = '0;
    foreach (mq[i]) v = (v << 8) | IMM_W'(mq[i]);
    return v;
  endfunction

  function automatic logic [3:0] ref_alu(input int opc);
    logic [3:0] tbl [0:16];
    tbl = '{4'hF, 4'hF, 4'hF, 4'h5, 4'h6, 4'h1, 4'h2, 4'h0, 4'hF,
            4'h9, 4'h7, 4'h8, 4'h3, 4'h4, 4'hA, 4'hB, 4'hC};
    return (opc <= 16) ? tbl[opc] : 4'hF;
  endfunction

  function automatic logic ref_rw(input int opc);
    return (opc inside {0, 1, [3:7], [12:16]});
  endfunction

  task automatic model_step();
    logic [7:0]       b;
    int               opc;
    logic [IMM_W-1:0] rv;
    exp_valid = 0; exp_branch = 0; exp_m2r = 0; exp_mw = 0; exp_rw = 0;
    exp_put = 0; exp_op = 0; exp_imm = 0; exp_ill = 0; exp_alu = 4'hF;
    if (rst) begin
      mq.delete(); m_last_vld = 0; m_wait = 0;
      exp_stall = 0; exp_value = '0; exp_ctr = '1;
    end else if (m_wait > 0) begin
      m_wait--;
      exp_stall = (m_wait > 0);
      if (m_wait == 0) begin
        exp_valid = 1; exp_m2r = 1; exp_rw = 1; exp_op = 1;
        exp_value = m_pend_value; exp_ctr = m_pend_ctr;
      end
    end else begin
      exp_stall = 0;
      if (instr_valid && (!m_last_vld || instr_ROM_ctr != m_last_ctr)) begin
        m_last_vld = 1; m_last_ctr = instr_ROM_ctr;
        b   = instruction[8:1];
        opc = int'(instruction[5:1]);
        if (instruction[0]) begin
          mq.push_back(b);
          if (mq.size() > IMM_W / 8) mq.delete(0);
          exp_valid = 1; exp_put = 1; exp_value = q_value(); exp_ctr = instr_ROM_ctr;
        end else begin
          rv = (mq.size() > 0) ? q_value() : IMM_W'(b);
          mq.delete();
          if (opc == 1 && MEM_WAIT > 0) begin
            m_wait = MEM_WAIT; exp_stall = 1;
            m_pend_value = rv; m_pend_ctr = instr_ROM_ctr;
          end else begin
            exp_valid = 1; exp_op = 1; exp_value = rv; exp_ctr = instr_ROM_ctr;
            exp_alu = ref_alu(opc); exp_rw = ref_rw(opc); exp_ill = (opc > 16);
            exp_imm = (opc == 0); exp_m2r = (opc == 1); exp_mw = (opc == 2); exp_branch = (opc == 8);
          end
        end
      end
    end
  endtask

  // Every-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("stall", stall, exp_stall);
      check("out_valid", out_valid, exp_valid);
      check("branchFlag", branchFlag, exp_branch);
      check("memToRegFlag", memToRegFlag, exp_m2r);
      check("memWriteFlag", memWriteFlag, exp_mw);
      check("regWriteFlag", regWriteFlag, exp_rw);
      check("putEn", putEn, exp_put);
      check("opEn", opEn, exp_op);
      check("immtoRegFlag", immtoRegFlag, exp_imm);
      check("illegal", illegal, exp_ill);
      check("ALUOp", ALUOp, exp_alu);
      check("value", value, exp_value);
      check("control_ctr", control_ctr, exp_ctr);
    end
  end

  task automatic cycle(input bit v, input logic [8:0] ins, input logic [CTR_W-1:0] pc, input bit r);
    rst = r; instr_valid = v; instruction = ins; instr_ROM_ctr = pc;
    @(posedge clk);
    model_step();
    chk_en = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [8:0] mk_run(input int opc);
    return {3'b000, opc[4:0], 1'b0};
  endfunction

  function automatic logic [8:0] mk_put(input logic [7:0] b);
    return {b, 1'b1};
  endfunction

  initial begin
    int pulses;
    logic [CTR_W-1:0] pc;
    logic [8:0] ins;
    int opc;
    rst = 1; instr_valid = 0; instruction = '0; instr_ROM_ctr = '0;

    // Reset state
    cycle(0, 9'h0, 12'h0, 1);
    check("rst_ctr", control_ctr, 12'hFFF);
    check("rst_alu", ALUOp, 4'hF);
    check("rst_value", value, 16'h0);
    check("rst_stall", stall, 1'b0);

    // Basic decode
    cycle(1, mk_run(3), 12'd5, 0);
    check("basic_valid", out_valid, 1'b1);
    check("basic_alu", ALUOp, 4'b0101);
    check("basic_rw", regWriteFlag, 1'b1);
    check("basic_op", opEn, 1'b1);
    check("basic_ctr", control_ctr, 12'd5);
    cycle(0, mk_run(3), 12'd5, 0);
    check("idle_valid", out_valid, 1'b0);
    check("idle_alu", ALUOp, 4'hF);

    // Duplicate suppression
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1, mk_run(5), 12'd7, 0);
      pulses += int'(out_valid);
    end
    check("dup_pulses", pulses, 1);
    cycle(1, mk_run(5), 12'd8, 0);
    check("dup_next", out_valid, 1'b1);

    // Immediate building
    cycle(1, mk_put(8'h12), 12'd1, 0);
    check("put1_value", value, 16'h0012);
    check("put1_en", putEn, 1'b1);
    cycle(1, mk_put(8'h34), 12'd2, 0);
    cycle(1, mk_run(0), 12'd3, 0);
    check("imm2_value", value, 16'h1234);
    check("imm2_flag", immtoRegFlag, 1'b1);
    cycle(1, mk_put(8'h12), 12'd4, 0);
    cycle(1, mk_put(8'h34), 12'd5, 0);
    cycle(1, mk_put(8'h56), 12'd6, 0);
    check("put_sat_value", value, 16'h3456);
    cycle(1, mk_run(0), 12'd7, 0);
    check("imm3_value", value, 16'h3456);

    // Load stall with PC 11 held during the wait
    cycle(1, mk_run(1), 12'd10, 0);
    check("ld_stall1", stall, 1'b1);
    check("ld_novalid", out_valid, 1'b0);
    cycle(1, mk_run(3), 12'd11, 0);
    check("ld_stall2", stall, 1'b1);
    check("ld_held", out_valid, 1'b0);
    cycle(1, mk_run(3), 12'd11, 0);
    check("ld_valid", out_valid, 1'b1);
    check("ld_m2r", memToRegFlag, 1'b1);
    check("ld_rw", regWriteFlag, 1'b1);
    check("ld_ctr", control_ctr, 12'd10);
    check("ld_stall_end", stall, 1'b0);
    cycle(1, mk_run(3), 12'd11, 0);
    check("after_ld_ctr", control_ctr, 12'd11);
    check("after_ld_alu", ALUOp, 4'b0101);

    // Reset during the second stall cycle discards the load
    cycle(1, mk_run(1), 12'd20, 0);
    cycle(0, mk_run(1), 12'd20, 0);
    check("rs_stall2", stall, 1'b1);
    cycle(0, mk_run(1), 12'd20, 1);
    check("rs_stall", stall, 1'b0);
    check("rs_valid", out_valid, 1'b0);
    check("rs_ctr", control_ctr, 12'hFFF);
    cycle(0, mk_run(1), 12'd20, 0);
    check("rs_discard", out_valid, 1'b0);

    // Illegal and branch-type opcodes
    cycle(1, mk_run(31), 12'd30, 0);
    check("ill_flag", illegal, 1'b1);
    check("ill_alu", ALUOp, 4'hF);
    check("ill_rw", regWriteFlag, 1'b0);
    cycle(1, mk_run(9), 12'd31, 0);
    check("br_alu", ALUOp, 4'b1001);
    check("br_rw", regWriteFlag, 1'b0);
    check("br_ill", illegal, 1'b0);

    // Counter wrap-around
    cycle(1, mk_run(12), 12'hFFF, 0);
    cycle(1, mk_run(13), 12'h000, 0);
    check("wrap_valid", out_valid, 1'b1);
    check("wrap_alu", ALUOp, 4'b0100);

    // Random traffic
    pc = 12'hFF0;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: pc = pc;
        9:       pc = CTR_W'($urandom_range(0, 4095));
        default: pc = pc + 12'd1;
      endcase
      if ($urandom_range(0, 9) < 4) begin
        ins = mk_put(8'($urandom_range(0, 255)));
      end else begin
        opc = ($urandom_range(0, 9) == 0) ? int'($urandom_range(17, 31)) : int'($urandom_range(0, 16));
        ins = mk_run(opc);
        ins[8:6] = 3'($urandom_range(0, 7));
      end
      cycle($urandom_range(0, 3) != 0, ins, pc, $urandom_range(0, 199) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
